// File: rtl/video_timing.sv
// Raster timing generator: pixel clock enable, h/v counters, sync, blanking and frame start.
// Define VIDEO_TIMING_OFFSET_EN to add per-frame signed sync offsets (h_offset/v_offset).
module video_timing #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 320,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 32,
  parameter int H_BACK    = 56,
  parameter int V_DISPLAY = 240,
  parameter int V_FRONT   = 12,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
`ifdef VIDEO_TIMING_OFFSET_EN
  input  logic [3:0] h_offset,
  input  logic [3:0] v_offset,
`endif
  output logic       cen,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic       frame_start
);

  // state   | meaning
  // ST_HOLD | not yet started (or lock lost); counters parked at 0/0, outputs 0
  // ST_RUN  | raster running, outputs follow counters on every cen

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] HS_BASE = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] VS_BASE = 10'(V_DISPLAY + V_FRONT);

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t             state;
  logic               sync0;
  logic               run;
  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [8:0]         h_next;
  logic [8:0]         v_next;
  logic [3:0]         h_off;
  logic [3:0]         v_off;
  logic [9:0]         hs_lo, hs_hi, vs_lo, vs_hi;
  logic               hsync_next, vsync_next;
  logic               wrap_to_origin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      run   <= 1'b0;
    end else begin
      sync0 <= locked;
      run   <= sync0;
    end
  end

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  // The first pixel after start is 0/0 itself, so the counters only advance once running.
  always_comb begin
    h_next = hcount;
    v_next = vcount;
    if (state == ST_HOLD) begin
      h_next = 9'd0;
      v_next = 9'd0;
    end else if (hcount == 9'(H_TOTAL - 1)) begin
      h_next = 9'd0;
      v_next = (vcount == 9'(V_TOTAL - 1)) ? 9'd0 : vcount + 9'd1;
    end else begin
      h_next = hcount + 9'd1;
    end
  end

  assign wrap_to_origin = (h_next == 9'd0) && (v_next == 9'd0);

`ifdef VIDEO_TIMING_OFFSET_EN
  // Offsets latch only at frame start so a mid-frame write never tears the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_off <= 4'd0;
      v_off <= 4'd0;
    end else if (!run) begin
      h_off <= 4'd0;
      v_off <= 4'd0;
    end else if (tick && wrap_to_origin) begin
      h_off <= h_offset;
      v_off <= v_offset;
    end
  end
`else
  assign h_off = 4'd0;
  assign v_off = 4'd0;
`endif

  // Offsets only move the sync windows; blanking stays tied to the display size.
  assign hs_lo = HS_BASE + {{6{h_off[3]}}, h_off};
  assign hs_hi = hs_lo + 10'(H_SYNC);
  assign vs_lo = VS_BASE + {{6{v_off[3]}}, v_off};
  assign vs_hi = vs_lo + 10'(V_SYNC);

  assign hsync_next = ({1'b0, h_next} >= hs_lo) && ({1'b0, h_next} < hs_hi);
  assign vsync_next = ({1'b0, v_next} >= vs_lo) && ({1'b0, v_next} < vs_hi);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_HOLD;
      div         <= '0;
      cen         <= 1'b0;
      hcount      <= 9'd0;
      vcount      <= 9'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else if (!run) begin
      state       <= ST_HOLD;
      div         <= '0;
      cen         <= 1'b0;
      hcount      <= 9'd0;
      vcount      <= 9'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      cen         <= tick;
      frame_start <= 1'b0;
      if (tick) begin
        state       <= ST_RUN;
        hcount      <= h_next;
        vcount      <= v_next;
        hsync       <= hsync_next;
        vsync       <= vsync_next;
        hblank      <= (h_next >= 9'(H_DISPLAY));
        vblank      <= (v_next >= 9'(V_DISPLAY));
        de          <= (h_next < 9'(H_DISPLAY)) && (v_next < 9'(V_DISPLAY));
        frame_start <= wrap_to_origin;
      end
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Randomized lock-drop / reset stimulus against an arithmetic raster model of video_timing.
// Define VIDEO_TIMING_OFFSET_EN to also exercise the per-frame sync offsets.
module tb_video_timing;

  localparam int CLK_DIV = 4;
  localparam int HD = 20, HF = 4, HS = 3, HB = 5;
  localparam int VD = 10, VF = 3, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic [3:0] h_offset;
  logic [3:0] v_offset;
  logic       cen, hsync, vsync, hblank, vblank, de, frame_start;
  logic [8:0] hcount, vcount;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit s0, s1, run_pre;
  int k = 0;
  int act_h = 0, act_v = 0;
  int de_cnt = 0;

  always #5 clk = ~clk;

  video_timing #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked),
`ifdef VIDEO_TIMING_OFFSET_EN
    .h_offset(h_offset), .v_offset(v_offset),
`endif
    .cen(cen), .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .de(de), .frame_start(frame_start)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cen"}, int'(cen), 0);
    check({tag, "_hcount"}, int'(hcount), 0);
    check({tag, "_vcount"}, int'(vcount), 0);
    check({tag, "_hsync"}, int'(hsync), 0);
    check({tag, "_vsync"}, int'(vsync), 0);
    check({tag, "_hblank"}, int'(hblank), 0);
    check({tag, "_vblank"}, int'(vblank), 0);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
  endtask

  // One clock: advance the model from the spec rules, then compare #1 after the edge.
  // k = consecutive edges seen with run high; pixel p starts at edge k = CLK_DIV*(p+1).
  task automatic step();
    bit started, e_cen, e_fs;
    int p, h, v;
    @(posedge clk);
    if (!rst_n) begin
      s0 = 0; s1 = 0; k = 0;
    end else begin
      run_pre = s1;
      s1 = s0;
      s0 = locked;
      k = run_pre ? k + 1 : 0;
    end
    started = (k >= CLK_DIV);
    p       = started ? (k - CLK_DIV) / CLK_DIV : 0;
    e_cen   = started && ((k - CLK_DIV) % CLK_DIV == 0);
    h       = p % HT;
    v       = (p / HT) % VT;
    e_fs    = e_cen && (p % (HT * VT) == 0);
`ifdef VIDEO_TIMING_OFFSET_EN
    if (e_fs) begin
      act_h = int'($signed(h_offset));
      act_v = int'($signed(v_offset));
    end
`endif
    #1;
    check("cen", int'(cen), int'(e_cen));
    check("hcount", int'(hcount), h);
    check("vcount", int'(vcount), v);
    check("hblank", int'(hblank), int'(started && h >= HD));
    check("vblank", int'(vblank), int'(started && v >= VD));
    check("de", int'(de), int'(started && h < HD && v < VD));
    check("hsync", int'(hsync), int'(started && h >= HD + HF + act_h && h < HD + HF + act_h + HS));
    check("vsync", int'(vsync), int'(started && v >= VD + VF + act_v && v < VD + VF + act_v + VS));
    check("frame_start", int'(frame_start), int'(e_fs));
    if (k == 0) de_cnt = 0;
    if (e_fs) begin
      if (p > 0) check("de_cens_per_frame", de_cnt, HD * VD);
      de_cnt = 0;
    end
    if (de && cen) de_cnt++;
  endtask

  task automatic random_offsets();
    h_offset = 4'($urandom_range(0, 6) - 3);
    v_offset = 4'($urandom_range(0, 6) - 3);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    locked = 1'b1;
    h_offset = 4'd0;
    v_offset = 4'd0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;

    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (cen) break;
    end
    check("first_cen_latency", n, 6);

    for (int i = 0; i < 2 * FRAME_CLKS + 500; i++) begin
      step();
      if ($urandom_range(0, 300) == 0) random_offsets();
    end

    for (int seg = 0; seg < 12; seg++) begin
      case ($urandom_range(0, 2))
        0: begin
          locked = 1'b0;
          repeat ($urandom_range(1, 20)) step();
          locked = 1'b1;
        end
        1: begin
          #1 rst_n = 1'b0;
          #1 check_all_zero("async_rst");
          repeat ($urandom_range(1, 4)) step();
          rst_n = 1'b1;
        end
        default: ;
      endcase
      n = $urandom_range(200, 2500);
      for (int i = 0; i < n; i++) begin
        step();
        if ($urandom_range(0, 300) == 0) random_offsets();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
